regfile_write_arbiter: RTL

Shares the single register-file write port of the RV32IM pipeline between in-order writeback (WB stage) and the iterative multiply/divide unit. Buffers M-unit results in a small FIFO, tracks M-unit destinations in a pending scoreboard, and raises a decode stall on RAW/WAW hazards against pending registers and on write-port starvation. Drives the register file's WRITE/INADDRESS/IN inputs directly.

---
 rtl/regfile_arb_pkg.sv | 16 +
 rtl/regfile_write_arbiter_fifo.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int XLEN             = 32;
    localparam int AW               = 5;
    localparam int NREG             = 1 << AW;
    localparam int MD_DEPTH_DEF     = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    // One buffered M-unit result: destination register and value.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } md_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// md_result_fifo: small synchronous FIFO holding M-unit results until the
// register-file write port is free. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate count.
module md_result_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = MD_DEPTH_DEF
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  md_entry_t i_data,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output md_entry_t o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    md_entry_t   r_mem [DEPTH];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_data;
        end
    end

    // Advance pointers on push/pop; reset discards all queued results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the in-order WB stage (always wins) and buffered M-unit results. Tracks
// outstanding M destinations and stalls decode on hazards against them.
// Optional feature macro RF_ARB_STARVE_GUARD_EN: when defined, a counter of
// consecutive lost arbitration cycles forces a decode stall so WB bubbles
// let the FIFO head drain; when undefined the FIFO may wait indefinitely.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int MD_DEPTH     = MD_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_md_valid,
    output logic            o_md_ready,
    input  logic [AW-1:0]   i_md_addr,
    input  logic [XLEN-1:0] i_md_data,
    input  logic            i_issue_md,
    input  logic [AW-1:0]   i_issue_addr,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    input  logic [AW-1:0]   i_rd_addr,
    output logic            o_stall,
    output logic            o_rf_write,
    output logic [AW-1:0]   o_rf_addr,
    output logic [XLEN-1:0] o_rf_data,
    output logic [NREG-1:0] o_pending
);

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_wb_grant;
    logic            w_starve_stall;
    md_entry_t       w_head;
    md_entry_t       w_md_entry;
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // A result to x0 completes its handshake but never occupies the FIFO.
    assign o_md_ready = !w_fifo_full;
    assign w_push     = i_md_valid && o_md_ready && (i_md_addr != '0);
    assign w_md_entry = '{addr: i_md_addr, data: i_md_data};

    assign w_wb_grant = i_wb_valid && (i_wb_addr != '0);
    assign w_pop      = !w_wb_grant && !w_fifo_empty;

    md_result_fifo #(
        .DEPTH (MD_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_data  (w_md_entry),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Write-port mux: WB first, otherwise the FIFO head, otherwise idle.
    always_comb begin
        o_rf_write = 1'b0;
        o_rf_addr  = '0;
        o_rf_data  = '0;
        if (w_wb_grant) begin
            o_rf_write = 1'b1;
            o_rf_addr  = i_wb_addr;
            o_rf_data  = i_wb_data;
        end else if (w_pop) begin
            o_rf_write = 1'b1;
            o_rf_addr  = w_head.addr;
            o_rf_data  = w_head.data;
        end
    end

    // Scoreboard next state: clear on pop first so a same-register issue wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head.addr] = 1'b0;
        end
        if (i_issue_md && (i_issue_addr != '0)) begin
            w_pending_nxt[i_issue_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Register the scoreboard.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_pending = r_pending;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve_cnt;

    // Count cycles the queued head loses to WB; saturate at the limit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (w_fifo_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_wb_grant && (r_starve_cnt < SW'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    assign w_starve_stall = (r_starve_cnt >= SW'(STARVE_LIMIT));
`else
    assign w_starve_stall = 1'b0;
`endif

    // Pending destinations block reads (RAW) and new writes (WAW) to them.
    assign o_stall = r_pending[i_rs1_addr] | r_pending[i_rs2_addr] |
                     r_pending[i_rd_addr]  | w_starve_stall;

endmodule
